// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache with a three-state fill FSM.
// A miss fetches one 16-byte block from instruction memory and then replays as a hit.
module instruction_cache #(
   parameter int LINES = 8,
   parameter int WORDS = 4
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  read,
   input  logic [31:0]           address,
   output logic [31:0]           instruction,
   output logic                  busywait,
   output logic                  mem_read,
   output logic [27:0]           mem_address,
   input  logic [32*WORDS-1:0]   mem_readdata,
   input  logic                  mem_busywait
);

   // state      | meaning
   // S_IDLE     | serve hits, detect misses and latch the block address
   // S_MEM_READ | mem_read held high until memory drops mem_busywait
   // S_UPDATE   | write returned block, tag and valid into the latched line
   typedef enum logic [1:0] {
      S_IDLE,
      S_MEM_READ,
      S_UPDATE
   } state_t;

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 28 - IDX_W;

   state_t                r_state;
   logic [LINES-1:0]      r_valid;
   logic [TAG_W-1:0]      r_tag  [LINES];
   logic [32*WORDS-1:0]   r_data [LINES];
   logic [27:0]           r_blk_addr;
   logic                  r_mem_read;
   logic [31:0]           r_instr;

   logic [IDX_W-1:0]      w_index;
   logic [TAG_W-1:0]      w_tag;
   logic                  w_hit;
   logic [32*WORDS-1:0]   w_line;
   logic [31:0]           w_word;
   logic                  w_serve;
   logic [IDX_W-1:0]      w_fill_idx;
   logic [TAG_W-1:0]      w_fill_tag;
   logic                  w_unused_addr_lsb;

   assign w_index    = address[4 +: IDX_W];
   assign w_tag      = address[31 -: TAG_W];
   assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
   assign w_line     = r_data[w_index];
   assign w_word     = w_line[{address[3:2], 5'b0} +: 32];
   assign w_fill_idx = r_blk_addr[IDX_W-1:0];
   assign w_fill_tag = r_blk_addr[27 -: TAG_W];
   assign w_unused_addr_lsb = &{1'b0, address[1:0]};

   // Hits are answered combinationally; otherwise the last fetched word is held.
   assign w_serve     = !RESET && (r_state == S_IDLE) && read && w_hit;
   assign instruction = w_serve ? w_word : r_instr;
   assign busywait    = !RESET && ((r_state != S_IDLE) || (read && !w_hit));
   assign mem_read    = r_mem_read;
   assign mem_address = r_blk_addr;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state    <= S_IDLE;
         r_valid    <= '0;
         r_mem_read <= 1'b0;
         r_instr    <= 32'h0;
         r_blk_addr <= 28'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (read) begin
                  if (w_hit) begin
                     r_instr <= w_word;
                  end else begin
                     r_blk_addr <= address[31:4];
                     r_mem_read <= 1'b1;
                     r_state    <= S_MEM_READ;
                  end
               end
            end
            S_MEM_READ: begin
               if (!mem_busywait) begin
                  r_mem_read <= 1'b0;
                  r_state    <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               r_data[w_fill_idx]  <= mem_readdata;
               r_tag[w_fill_idx]   <= w_fill_tag;
               r_valid[w_fill_idx] <= 1'b1;
               r_state             <= S_IDLE;
            end
            default: begin
               r_mem_read <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a behavioural instruction memory.
// Each block's word i reads back as its own byte address, except block 0.
module tb_instruction_cache;

   logic          CLK = 1'b0;
   logic          RESET = 1'b0;
   logic          read = 1'b0;
   logic [31:0]   address = 32'h0;
   logic [31:0]   instruction;
   logic          busywait;
   logic          mem_read;
   logic [27:0]   mem_address;
   logic [127:0]  mem_readdata;
   logic          mem_busywait;

   int n_checks = 0;
   int n_pass   = 0;
   int mem_wait = 3;
   int mcnt     = 0;

   instruction_cache #(.LINES(8), .WORDS(4)) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .read         (read),
      .address      (address),
      .instruction  (instruction),
      .busywait     (busywait),
      .mem_read     (mem_read),
      .mem_address  (mem_address),
      .mem_readdata (mem_readdata),
      .mem_busywait (mem_busywait)
   );

   always #5 CLK = ~CLK;

   function automatic logic [127:0] mem_block(input logic [27:0] blk);
      logic [127:0] b;
      if (blk == 28'h0) return 128'h00000013_00000013_00000093_00500113;
      for (int i = 0; i < 4; i++) b[32*i +: 32] = {blk, 4'(i * 4)};
      return b;
   endfunction

   // Memory answers on the mem_wait-th cycle of mem_read.
   always @(posedge CLK) begin
      if (mem_read) mcnt <= mcnt + 1;
      else          mcnt <= 0;
   end
   assign mem_busywait = ~(mem_read && (mcnt >= mem_wait - 1));
   always_comb mem_readdata = mem_block(mem_address);

   task automatic fetch(input logic [31:0] a, output int bw, output logic [31:0] ins,
                        output logic [27:0] maddr, output bit mstable, output bit tmo);
      bit seen = 0;
      bw = 0; ins = 32'h0; maddr = 28'h0; mstable = 1; tmo = 1;
      for (int c = 0; c < 40; c++) begin
         @(negedge CLK);
         read = 1'b1; address = a;
         #1;
         if (!busywait) begin
            ins = instruction; tmo = 0;
            break;
         end
         bw++;
         if (mem_read) begin
            if (!seen) begin maddr = mem_address; seen = 1; end
            else if (mem_address !== maddr) mstable = 0;
         end
      end
      if (!seen) mstable = 0;
   endtask

   task automatic test_reset();
      @(negedge CLK); RESET = 1'b1; read = 1'b1; address = 32'h0;
      @(negedge CLK); #1;
      n_checks++;
      if (busywait !== 1'b0) $display("FAIL reset_busywait: got %b expected 0", busywait);
      else n_pass++;
      n_checks++;
      if (mem_read !== 1'b0) $display("FAIL reset_mem_read: got %b expected 0", mem_read);
      else n_pass++;
      @(negedge CLK); RESET = 1'b0; read = 1'b0; #1;
      n_checks++;
      if (instruction !== 32'h0) $display("FAIL reset_instruction: got %h expected 00000000", instruction);
      else n_pass++;
   endtask

   task automatic test_cold_miss();
      int bw; logic [31:0] ins; logic [27:0] ma; bit st, tmo;
      fetch(32'h0, bw, ins, ma, st, tmo);
      n_checks++;
      if (tmo || bw != 5) $display("FAIL cold_busy_cycles: got %0d (timeout %0d) expected 5", bw, tmo);
      else n_pass++;
      n_checks++;
      if (ma !== 28'h0 || !st) $display("FAIL cold_mem_address: got %h stable %0d expected 0000000 stable 1", ma, st);
      else n_pass++;
      n_checks++;
      if (ins !== 32'h00500113) $display("FAIL cold_instruction: got %h expected 00500113", ins);
      else n_pass++;
   endtask

   task automatic test_spatial_hit();
      logic [31:0] addrs [3] = '{32'h4, 32'h8, 32'hC};
      logic [31:0] exps  [3] = '{32'h00000093, 32'h00000013, 32'h00000013};
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK); read = 1'b1; address = addrs[i]; #1;
         n_checks++;
         if (instruction !== exps[i] || busywait !== 1'b0 || mem_read !== 1'b0)
            $display("FAIL spatial_hit_%0d: got instr %h bw %b mr %b expected %h 0 0",
                     i, instruction, busywait, mem_read, exps[i]);
         else n_pass++;
      end
      @(negedge CLK); read = 1'b0; address = 32'h40; #1;
      n_checks++;
      if (instruction !== 32'h00000013 || busywait !== 1'b0)
         $display("FAIL idle_hold: got instr %h bw %b expected 00000013 0", instruction, busywait);
      else n_pass++;
   endtask

   task automatic test_conflict();
      int bw; logic [31:0] ins; logic [27:0] ma; bit st, tmo;
      fetch(32'h80, bw, ins, ma, st, tmo);
      n_checks++;
      if (tmo || bw != 5 || ma !== 28'h8 || !st || ins !== 32'h80)
         $display("FAIL conflict_fill: got bw %0d ma %h instr %h expected 5 0000008 00000080", bw, ma, ins);
      else n_pass++;
      fetch(32'h0, bw, ins, ma, st, tmo);
      n_checks++;
      if (tmo || bw != 5 || ma !== 28'h0 || ins !== 32'h00500113)
         $display("FAIL conflict_refill: got bw %0d ma %h instr %h expected 5 0000000 00500113", bw, ma, ins);
      else n_pass++;
   endtask

   task automatic test_addr_change();
      int bw; logic [31:0] ins; logic [27:0] ma; bit st, tmo;
      @(negedge CLK); read = 1'b1; address = 32'h40; #1;
      n_checks++;
      if (busywait !== 1'b1) $display("FAIL chg_miss_detect: got %b expected 1", busywait);
      else n_pass++;
      // cycles 1..3 are MEM_READ, cycle 4 is UPDATE with read dropped
      for (int i = 1; i <= 4; i++) begin
         @(negedge CLK); address = 32'h100; read = (i < 4); #1;
         n_checks++;
         if (busywait !== 1'b1 || mem_read !== (i <= 3) || (i <= 3 && mem_address !== 28'h4))
            $display("FAIL chg_cycle_%0d: got bw %b mr %b ma %h expected 1 %0d 0000004",
                     i, busywait, mem_read, mem_address, (i <= 3));
         else n_pass++;
      end
      @(negedge CLK); read = 1'b0; #1;
      n_checks++;
      if (busywait !== 1'b0) $display("FAIL chg_back_idle: got %b expected 0", busywait);
      else n_pass++;
      fetch(32'h44, bw, ins, ma, st, tmo);
      n_checks++;
      if (tmo || bw != 0 || ins !== 32'h44)
         $display("FAIL chg_line4_hit: got bw %0d instr %h expected 0 00000044", bw, ins);
      else n_pass++;
   endtask

   task automatic test_reset_mid_fill();
      int bw; logic [31:0] ins; logic [27:0] ma; bit st, tmo;
      @(negedge CLK); read = 1'b1; address = 32'hC0;
      @(negedge CLK); #1;
      n_checks++;
      if (mem_read !== 1'b1) $display("FAIL rst_fill_started: got %b expected 1", mem_read);
      else n_pass++;
      @(negedge CLK); RESET = 1'b1; #1;
      n_checks++;
      if (busywait !== 1'b0) $display("FAIL rst_fill_busywait: got %b expected 0", busywait);
      else n_pass++;
      @(negedge CLK); RESET = 1'b0; read = 1'b0; #1;
      n_checks++;
      if (mem_read !== 1'b0 || busywait !== 1'b0 || instruction !== 32'h0)
         $display("FAIL rst_fill_idle: got mr %b bw %b instr %h expected 0 0 00000000",
                  mem_read, busywait, instruction);
      else n_pass++;
      fetch(32'hC0, bw, ins, ma, st, tmo);
      n_checks++;
      if (tmo || bw != 5 || ma !== 28'hC || ins !== 32'hC0)
         $display("FAIL rst_fill_remiss: got bw %0d ma %h instr %h expected 5 000000c 000000c0", bw, ma, ins);
      else n_pass++;
      fetch(32'h0, bw, ins, ma, st, tmo);
      n_checks++;
      if (tmo || bw != 5 || ins !== 32'h00500113)
         $display("FAIL rst_valid_cleared: got bw %0d instr %h expected 5 00500113", bw, ins);
      else n_pass++;
   endtask

   task automatic test_top_address();
      int bw; logic [31:0] ins; logic [27:0] ma; bit st, tmo;
      fetch(32'hFFFF_FFFC, bw, ins, ma, st, tmo);
      n_checks++;
      if (tmo || bw != 5 || ma !== 28'hFFFFFFF || !st)
         $display("FAIL top_fill: got bw %0d ma %h expected 5 fffffff", bw, ma);
      else n_pass++;
      n_checks++;
      if (ins !== 32'hFFFF_FFFC) $display("FAIL top_instruction: got %h expected fffffffc", ins);
      else n_pass++;
      fetch(32'hFFFF_FFF0, bw, ins, ma, st, tmo);
      n_checks++;
      if (tmo || bw != 0 || ins !== 32'hFFFF_FFF0)
         $display("FAIL top_word0_hit: got bw %0d instr %h expected 0 fffffff0", bw, ins);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int bw; logic [31:0] ins; logic [27:0] ma; bit st, tmo;
      mem_wait = 1;
      fetch(32'h208, bw, ins, ma, st, tmo);
      n_checks++;
      if (tmo || bw != 3 || ma !== 28'h20 || ins !== 32'h208)
         $display("FAIL fast_mem_fill: got bw %0d ma %h instr %h expected 3 0000020 00000208", bw, ma, ins);
      else n_pass++;
      fetch(32'h20C, bw, ins, ma, st, tmo);
      n_checks++;
      if (tmo || bw != 0 || ins !== 32'h20C)
         $display("FAIL fast_mem_hit: got bw %0d instr %h expected 0 0000020c", bw, ins);
      else n_pass++;
      mem_wait = 3;
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_spatial_hit();
      test_conflict();
      test_addr_change();
      test_reset_mid_fill();
      test_top_address();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/instruction_cache.md
INSTRUCTION_CACHE -- requirements
Module: instruction_cache

Interface
REQ-001 SHALL have the ports, clock and reset first:
- CLK  input  1  single clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- read  input  1  fetch request for address this cycle.
- address  input  32  byte address of instruction (program counter value).
- instruction  output  32  fetched instruction word.
- busywait  output  1  high while a request cannot complete; PC SHALL hold.
- mem_read  output  1  read request to instruction memory.
- mem_address  output  28  block address to memory (address[31:4]).
- mem_readdata  input  128  full block from memory, word 0 in bits [31:0].
- mem_busywait  input  1  high while memory has not yet returned data.

REQ-002 SHALL have parameters:
- LINES, default 8, number of direct-mapped lines.
- WORDS, fixed at 4, words per line (16-byte block).

Function
REQ-003 SHALL be direct-mapped:
- address[1:0] ignored.
- offset = address[3:2].
- index = address[6:4].
- tag = address[31:7] (25 bits).
REQ-004 SHALL store per line a valid bit, a 25-bit tag and 128 bits of data.
REQ-005 SHALL compute hit combinationally as: valid[index] AND tag[index]==tag.
REQ-006 SHALL use the FSM states IDLE, MEM_READ and UPDATE; the reset state SHALL be IDLE.
REQ-007 IDLE behaviour:
- read=1 and hit: instruction = selected word of the line in the same cycle, busywait=0, stay in IDLE.
- read=1 and miss: busywait=1 in the same cycle; latch address[31:4]; next state MEM_READ.
- read=0: busywait=0, instruction holds its last value.
REQ-008 MEM_READ behaviour:
- mem_read=1 and mem_address = latched block address, held stable for the whole state.
- busywait=1.
- Leave the state on the first edge where mem_busywait=0; next state UPDATE.
REQ-009 UPDATE behaviour:
- mem_read=0, busywait=1.
- On the edge: write mem_readdata into the line at the latched index, set tag to the latched tag, set valid=1.
- Next state IDLE.
REQ-010 After UPDATE, the re-presented address SHALL hit in IDLE. Miss penalty = 2 + (memory wait cycles) cycles of busywait.
REQ-011 SHALL use the latched address for the whole fill; changes on address during MEM_READ or UPDATE SHALL NOT alter mem_address or the line written.
REQ-012 SHALL issue mem_read only in MEM_READ; it SHALL never assert mem_read in IDLE or UPDATE.
REQ-013 A line with valid=0 SHALL miss even when its stored tag equals the request tag, including address 0x00000000 after reset.
REQ-014 A miss to an occupied line SHALL overwrite it with no writeback (read-only cache).
REQ-015 SHALL serve the request at address 0xFFFFFFFC (tag all ones, index 7, offset 3) with no wrap or overflow side effects.
REQ-016 read=0 during MEM_READ or UPDATE SHALL NOT abort the fill; the fill completes and the FSM returns to IDLE.

Reset
REQ-017 When RESET=1 at a rising edge, the block SHALL:
- go to state IDLE;
- clear every valid bit;
- drive mem_read=0 and instruction=32'h0 from that edge;
- leave tag and data contents don't-care.
REQ-018 With RESET=1 mid-fill (MEM_READ or UPDATE), the block SHALL abandon the fill and SHALL NOT write the line; mem_read SHALL be 0 after the edge.
REQ-019 While RESET=1, busywait SHALL be 0.

Verification
REQ-020 Cold miss: after reset, read=1, address=0x00000000; memory returns 0x00000013_00000013_00000093_00500113 after 3 wait cycles.
- Required: busywait high for exactly 5 cycles.
- Required: mem_address=0x0000000 during fill.
- Required: then instruction=0x00500113 with busywait=0.
REQ-021 Spatial hit: following REQ-020, address=0x00000004, 0x00000008, 0x0000000C.
- Required: 0x00000093, 0x00000013, 0x00000013 on consecutive cycles.
- Required: busywait=0 throughout, mem_read never asserted.
REQ-022 Conflict: fill 0x00000000, then read 0x00000080 (same index 0, new tag).
- Required: miss with mem_address=0x0000008.
- Required: a subsequent read of 0x00000000 misses again.
REQ-023 Address change mid-fill: miss on 0x00000040, then change address to 0x00000100 during MEM_READ.
- Required: mem_address stays 0x0000004 and line 4 is filled.
REQ-024 Reset mid-fill: assert RESET for one cycle during MEM_READ.
- Required: mem_read=0 next cycle and FSM in IDLE.
- Required: re-read of the same address misses (valid cleared).
REQ-025 Top address: read 0xFFFFFFFC.
- Required: mem_address=0xFFFFFFF.
- Required: instruction = bits [127:96] of the returned block.
